button_conditioner: RTL and testbench
=====================================

// Module: button_conditioner
// PURPOSE
//  Conditions raw push-button inputs (BTNU, BTND) before they reach buttonWidget/paddle logic.
//  Per button: synchronise, debounce, emit a stable level, one-clock press/release pulses,
//  and an auto-repeat pulse stream paced by the shared clockDiv tick (wEn) while held.
//  Sits directly upstream of the paddle widget in the FirstVGA top level.
// PARAMETERS
//  NUM_BTN          2        number of independent button channels
//  SYNC_STAGES      2        flip-flops in the input synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  1000000  consecutive clk cycles of disagreement required to flip level (10 ms @100 MHz)
//  DB_W             20       debounce counter width; must hold DEBOUNCE_CYCLES-1
//  REPEAT_DELAY     30       ticks from press to first repeat pulse
//  REPEAT_RATE      4        ticks between subsequent repeat pulses
//  RPT_W            8        repeat counter width; must hold max(REPEAT_DELAY,REPEAT_RATE)
// PORTS
//  clk        in   1        system clock, 100 MHz
//  reset      in   1        asynchronous, active-high reset
//  tick       in   1        one-clk pacing strobe (clockDiv divPulse)
//  btnRaw     in   NUM_BTN  raw, asynchronous button pins
//  level      out  NUM_BTN  debounced button state (1 = held)
//  press      out  NUM_BTN  one-clk pulse on debounced 0->1
//  release    out  NUM_BTN  one-clk pulse on debounced 1->0
//  repeatP    out  NUM_BTN  one-clk auto-repeat pulse while held
// BEHAVIOUR
//  - Reset (async assert, sync release): sync chain, counters, level, press, release, repeatP all 0.
//  - Channels fully independent; no cross-channel priority.
//  - Sync: btnRaw[i] through SYNC_STAGES flops -> s[i]; all later logic uses s[i] only.
//  - Debounce FSM per channel, states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO:
//    STABLE_LO: s=1 -> CHK_HI, cnt=0.  CHK_HI: s=0 -> STABLE_LO (bounce, no output);
//    s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, level<=1, press<=1; else cnt++.
//    STABLE_HI/CHK_LO mirror this, producing level<=0, release<=1.
//  - Latency: raw edge held clean -> level/press change SYNC_STAGES+DEBOUNCE_CYCLES clks later.
//  - press/release/repeatP are registered, high exactly one clk, then 0 unless re-triggered.
//  - Repeat: on press, rcnt<=0, phase=DELAY. While level==1, each tick increments rcnt;
//    the tick that makes rcnt reach REPEAT_DELAY (DELAY phase) or REPEAT_RATE (RATE phase)
//    sets repeatP<=1 on the next clk, rcnt<=0, phase<=RATE.
//  - Release (or level==0) clears rcnt and phase immediately; a tick in the same clk as
//    the release pulse produces no repeatP.
//  - tick coincident with press: ignored (counting starts at the next tick).
//  - Counters saturate-free by construction; no wrap possible because thresholds reset them.
//  - Reset mid-hold: outputs drop to 0 at once; after release, a still-held button is
//    debounced as a fresh press (full latency, new press pulse).
// STRUCTURE
//  - Sub-module btn_debounce_chan: one channel (sync + FSM + repeat); top generates NUM_BTN copies.
//  - Shared include vga_defs.vh: CLK_HZ (100000000), FSM state encodings
//    (ST_STABLE_LO=2'd0, ST_CHK_HI=2'd1, ST_STABLE_HI=2'd2, ST_CHK_LO=2'd3),
//    default DEBOUNCE_CYCLES/REPEAT constants.
// TESTING  (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2, tick every 5 clks)
//  1 Clean press: btnRaw[0] 0->1 at clk 0, held -> level[0]=1 and press[0]=1 at clk 6;
//    press low again at clk 7; no release.
//  2 Bounce: raw high 3 clks, low 1 clk, high steady -> level[0] rises 6 clks after final
//    rising edge; exactly one press pulse; no pulse during bounce.
//  3 Hold: after press, repeatP[0] one clk after 3rd tick, then one clk after every 2nd tick;
//    count 5 repeats over 11 ticks.
//  4 Release: raw 1->0 -> release[0] at +6 clks, level 0; tick forced into release clk ->
//    no repeatP; no repeatP thereafter.
//  5 Reset mid-hold: assert reset async between clk edges -> all outputs 0 within same
//    cycle; deassert with raw still 1 -> new press at 6 clks after deassert.
//  6 Independence: BTNU and BTND pressed 2 clks apart, bounced differently -> each channel
//    matches its own expected timing; no interaction in level/press/repeatP.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants and state encodings for the push-button conditioner.
package button_conditioner_pkg;

  localparam int CLK_HZ                  = 100_000_000;
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_DEBOUNCE_CYCLES     = 1_000_000;  // 10 ms at CLK_HZ
  localparam int DEF_DB_W                = 20;
  localparam int DEF_REPEAT_DELAY        = 30;
  localparam int DEF_REPEAT_RATE         = 4;
  localparam int DEF_RPT_W               = 8;

  // Debounce states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_CHK_HI    = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_CHK_LO    = 2'd3
  } db_state_t;

  // Auto-repeat pacing: first gap is the long delay, later gaps the short rate.
  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } rpt_phase_t;

endpackage

// File: rtl/button_conditioner_chan.sv
// One button channel: input synchroniser, debounce FSM, edge pulses and
// tick-paced auto-repeat. All pulse outputs are registered one-clock strobes.
module btn_debounce_chan
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int RPT_W           = DEF_RPT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output logic       releaseP,
  output logic       repeatP,
  output logic [1:0] state
);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_RATE_V  = RPT_W'(REPEAT_RATE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  db_state_t        cur_state, nxt_state;
  logic [DB_W-1:0]  cnt, cnt_next;
  logic             level_next, press_next, rel_next;

  logic [RPT_W-1:0] rcnt, rcnt_next, rcnt_inc, rpt_limit;
  rpt_phase_t       phase, phase_next;
  logic             rpt_next;

  assign s     = sync_q[SYNC_STAGES-1];
  assign state = cur_state;

  // Synchronise the asynchronous pin; nothing downstream looks at raw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Debounce next-state: a level flips only after an unbroken run of
  // disagreeing samples; any agreeing sample abandons the check silently.
  always_comb begin
    nxt_state  = cur_state;
    cnt_next   = cnt;
    level_next = level;
    press_next = 1'b0;
    rel_next   = 1'b0;
    case (cur_state)
      ST_STABLE_LO: if (s) begin
        nxt_state = ST_CHK_HI;
        cnt_next  = '0;
      end
      ST_CHK_HI: begin
        if (!s) nxt_state = ST_STABLE_LO;
        else if (cnt == DB_LAST) begin
          nxt_state  = ST_STABLE_HI;
          level_next = 1'b1;
          press_next = 1'b1;
        end else cnt_next = cnt + DB_W'(1);
      end
      ST_STABLE_HI: if (!s) begin
        nxt_state = ST_CHK_LO;
        cnt_next  = '0;
      end
      ST_CHK_LO: begin
        if (s) nxt_state = ST_STABLE_HI;
        else if (cnt == DB_LAST) begin
          nxt_state  = ST_STABLE_LO;
          level_next = 1'b0;
          rel_next   = 1'b1;
        end else cnt_next = cnt + DB_W'(1);
      end
    endcase
  end

  assign rcnt_inc  = rcnt + RPT_W'(1);
  assign rpt_limit = (phase == PH_DELAY) ? RPT_DELAY_V : RPT_RATE_V;

  // Repeat pacing. The counter is cleared on the edge that presses or releases,
  // so a tick on a release edge, or during the press pulse clock, never counts.
  always_comb begin
    rcnt_next  = rcnt;
    phase_next = phase;
    rpt_next   = 1'b0;
    if (!level_next || press_next) begin
      rcnt_next  = '0;
      phase_next = PH_DELAY;
    end else if (!press && tick) begin
      if (rcnt_inc == rpt_limit) begin
        rpt_next   = 1'b1;
        rcnt_next  = '0;
        phase_next = PH_RATE;
      end else begin
        rcnt_next = rcnt_inc;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_STABLE_LO;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      releaseP  <= 1'b0;
      repeatP   <= 1'b0;
      rcnt      <= '0;
      phase     <= PH_DELAY;
    end else begin
      cur_state <= nxt_state;
      cnt       <= cnt_next;
      level     <= level_next;
      press     <= press_next;
      releaseP  <= rel_next;
      repeatP   <= rpt_next;
      rcnt      <= rcnt_next;
      phase     <= phase_next;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: NUM_BTN independent debounce/repeat channels.
// The release pulse port is named releaseP because "release" is a reserved word.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DB_W            = DEF_DB_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int RPT_W           = DEF_RPT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [NUM_BTN-1:0]     btnRaw,
  output logic [NUM_BTN-1:0]     level,
  output logic [NUM_BTN-1:0]     press,
  output logic [NUM_BTN-1:0]     releaseP,
  output logic [NUM_BTN-1:0]     repeatP,
  output logic [2*NUM_BTN-1:0]   dbg_state
);

  // One self-contained channel per button; no shared state between them.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .RPT_W          (RPT_W)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick),
      .raw     (btnRaw[i]),
      .level   (level[i]),
      .press   (press[i]),
      .releaseP(releaseP[i]),
      .repeatP (repeatP[i]),
      .state   (dbg_state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing scenarios plus a random soak,
// all checked per clock against a window-based reference model via a queue.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 3;
  localparam int RR = 2;

  logic          clk, rst, tick;
  logic [NB-1:0] btn_raw, level, press, releaseP, repeatP;
  logic [2*NB-1:0] dbg_state;

  button_conditioner #(
    .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .DB_W(20),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .RPT_W(8)
  ) dut (
    .clk(clk), .reset(rst), .tick(tick), .btnRaw(btn_raw),
    .level(level), .press(press), .releaseP(releaseP), .repeatP(repeatP),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int rep_cnt0 = 0;
  int tick_mode = 0;   // 0: every 5 clks, 1: random, 2: driven by main thread
  int tick_div  = 0;

  logic [8-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- tick driver ----------------
  always @(posedge clk) begin
    #2;
    if (tick_mode == 0) begin
      tick = (tick_div == 0);
      tick_div = (tick_div + 1) % 5;
    end else if (tick_mode == 1) begin
      tick = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- reference model ----------------
  // Level flips when the last DC+1 synchronised samples (raw delayed by SS
  // clocks) all disagree with it. Repeats fire on tick number RD after the
  // press and every RR ticks after that; ticks during the press pulse don't count.
  logic [SS+DC:0] m_hist [NB];
  logic [NB-1:0]  m_level, m_press, m_rel, m_rep;
  int             m_ticks [NB];

  always @(posedge clk) begin
    logic [SS+DC:0] h;
    logic           diff, nl;
    if (rst) begin
      for (int c = 0; c < NB; c++) begin
        m_hist[c] = '0;
        m_ticks[c] = 0;
      end
      m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
    end else begin
      for (int c = 0; c < NB; c++) begin
        h = {m_hist[c][SS+DC-1:0], btn_raw[c]};
        m_hist[c] = h;
        diff = 1'b1;
        for (int j = SS; j <= SS + DC; j++)
          if (h[j] == m_level[c]) diff = 1'b0;
        nl = diff ? ~m_level[c] : m_level[c];
        m_rep[c] = 1'b0;
        if (!nl || !m_level[c]) begin
          m_ticks[c] = 0;
        end else if (!m_press[c] && tick) begin
          m_ticks[c]++;
          m_rep[c] = (m_ticks[c] == RD) ||
                     (m_ticks[c] > RD && ((m_ticks[c] - RD) % RR) == 0);
        end
        m_press[c] = nl & ~m_level[c];
        m_rel[c]   = ~nl & m_level[c];
        m_level[c] = nl;
      end
      exp_q.push_back({m_level, m_press, m_rel, m_rep});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] got, e;
    got = {level, press, releaseP, repeatP};
    if (rst) begin
      exp_q.delete();
      check("reset_outputs", {24'd0, got}, 32'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("scoreboard", {24'd0, got}, {24'd0, e});
      if (repeatP[0]) rep_cnt0++;
    end
  end

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    summary();
    $finish;
  end

  // ---------------- stimulus ----------------
  int run_left [NB];
  int r0;

  initial begin
    rst = 1'b1; btn_raw = '0; tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);

    // 1: clean press on channel 0, sampled first at edge 0
    @(posedge clk); #2; btn_raw = 2'b01;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      check("s1_level",   {31'd0, level[0]},    {31'd0, n >= 6});
      check("s1_press",   {31'd0, press[0]},    {31'd0, n == 6});
      check("s1_release", {31'd0, releaseP[0]}, 32'd0);
    end

    // 3: hold with 11 ticks, 5 clocks apart
    tick_mode = 2; tick = 1'b0;
    r0 = rep_cnt0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #2; tick = 1'b1;
      @(posedge clk); #2; tick = 1'b0;
      @(negedge clk);
      check("s3_repeat", {31'd0, repeatP[0]},
            {31'd0, (k == RD) || (k > RD && ((k - RD) % RR) == 0)});
      repeat (3) @(posedge clk);
    end
    #1 check("s3_repeat_count", rep_cnt0 - r0, 32'd5);

    // 4: release with ticks on the release edge and in the release pulse clock
    @(posedge clk); #2; tick = 1'b1;
    @(posedge clk); #2; tick = 1'b0;
    @(posedge clk); #2; btn_raw = 2'b00;
    for (int n = 0; n < 9; n++) begin
      @(posedge clk); #2; tick = (n == 5 || n == 6);
      @(negedge clk);
      check("s4_release", {31'd0, releaseP[0]}, {31'd0, n == 6});
      check("s4_level",   {31'd0, level[0]},    {31'd0, n < 6});
      check("s4_repeat",  {31'd0, repeatP[0]},  32'd0);
    end
    tick = 1'b0;
    repeat (10) @(posedge clk);

    // 2: bounce: high 3 clks, low 1, then steady high
    tick_mode = 0;
    @(posedge clk); #2; btn_raw = 2'b01;
    for (int n = 0; n < 13; n++) begin
      @(posedge clk); #2; btn_raw[0] = (n != 2);
      @(negedge clk);
      check("s2_level", {31'd0, level[0]}, {31'd0, n >= 10});
      check("s2_press", {31'd0, press[0]}, {31'd0, n == 10});
    end

    // 5: asynchronous reset while held, then fresh press after release
    repeat (20) @(posedge clk);
    @(negedge clk); #1; rst = 1'b1;
    #1 check("s5_async_clear", {24'd0, level, press, releaseP, repeatP}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); @(negedge clk);
      check("s5_press", {31'd0, press[0]}, {31'd0, n == 6});
      check("s5_level", {31'd0, level[0]}, {31'd0, n >= 6});
    end
    @(posedge clk); #2; btn_raw = 2'b00;
    repeat (12) @(posedge clk);

    // 6: both channels, 1 pressed cleanly, 2 later with a bounce
    #2; btn_raw = 2'b01;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #2; btn_raw[1] = (n == 1 || n == 2 || n >= 4);
      @(negedge clk);
      check("s6_press", {30'd0, press}, {30'd0, n == 11, n == 6});
      check("s6_level", {30'd0, level}, {30'd0, n >= 11, n >= 6});
    end
    @(posedge clk); #2; btn_raw = 2'b00;
    repeat (12) @(posedge clk);

    // random soak: bursts of bounce mixed with long holds, random ticks
    tick_mode = 1;
    for (int c = 0; c < NB; c++) run_left[c] = $urandom_range(1, 10);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #2;
      if (cyc == 1500) rst = 1'b1;
      if (cyc == 1503) rst = 1'b0;
      for (int c = 0; c < NB; c++) begin
        if (run_left[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          run_left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                     : $urandom_range(5, 60);
        end else begin
          run_left[c]--;
        end
      end
    end

    tick_mode = 2; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("sb_depth", exp_q.size(), 32'd1);
    summary();
    $finish;
  end

endmodule
